// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide engine for the HI/LO pair: radix-2 Booth multiply,
// restoring divide, one bit per clock, fixed latency for every op and operand.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CW-1:0]    count;
    logic [1:0]       op_q;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   mcand;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] a_q;
    logic             q_1;
    logic             a_neg;
    logic             b_neg;
    logic             b_msb;
    logic             b_zero;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   load_mcand;
    logic [WIDTH-1:0] load_mq;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] lo_fix;
    logic [WIDTH-1:0] hi_fix;
    logic             dbz_fix;

    // State register
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_CALC;
            ST_CALC: if (count == LAST) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand preparation at accept: divide works on magnitudes, multiply on extended a
    always_comb begin
        a_mag = (!op[0] && a[WIDTH-1]) ? -a : a;
        b_mag = (!op[0] && b[WIDTH-1]) ? -b : b;
        if (op[1]) begin
            load_mcand = {1'b0, b_mag};
            load_mq    = a_mag;
        end else begin
            load_mcand = {(!op[0]) & a[WIDTH-1], a};
            load_mq    = b;
        end
    end

    // One iteration of Booth recoding and of restoring division
    always_comb begin
        case ({mq[0], q_1})
            2'b10:   booth_sum = acc - mcand;
            2'b01:   booth_sum = acc + mcand;
            default: booth_sum = acc;
        endcase
        div_shift = {acc[WIDTH-1:0], mq[WIDTH-1]};
        div_trial = div_shift - mcand;
    end

    // Final sign/zero fix-up; unsigned multiply adds back the weight Booth gives b's MSB
    always_comb begin
        lo_fix  = mq;
        hi_fix  = acc[WIDTH-1:0];
        dbz_fix = 1'b0;
        if (!op_q[1]) begin
            if (op_q[0] && b_msb) hi_fix = acc[WIDTH-1:0] + a_q;
        end else if (b_zero) begin
            lo_fix  = '1;
            hi_fix  = a_q;
            dbz_fix = 1'b1;
        end else begin
            if (a_neg ^ b_neg) lo_fix = -mq;
            if (a_neg) hi_fix = -acc[WIDTH-1:0];
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            lo          <= '0;
            hi          <= '0;
            div_by_zero <= 1'b0;
            count       <= '0;
            op_q        <= '0;
            acc         <= '0;
            mcand       <= '0;
            mq          <= '0;
            a_q         <= '0;
            q_1         <= 1'b0;
            a_neg       <= 1'b0;
            b_neg       <= 1'b0;
            b_msb       <= 1'b0;
            b_zero      <= 1'b0;
        end else begin
            busy <= (state_nxt == ST_CALC) || (state_nxt == ST_FIX);
            done <= (state_nxt == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q        <= op;
                        a_q         <= a;
                        a_neg       <= !op[0] && a[WIDTH-1];
                        b_neg       <= !op[0] && b[WIDTH-1];
                        b_msb       <= b[WIDTH-1];
                        b_zero      <= (b == '0);
                        acc         <= '0;
                        q_1         <= 1'b0;
                        count       <= '0;
                        mcand       <= load_mcand;
                        mq          <= load_mq;
                        div_by_zero <= 1'b0;
                    end
                end
                ST_CALC: begin
                    count <= count + CW'(1);
                    if (op_q[1]) begin
                        if (!div_trial[WIDTH]) begin
                            acc <= div_trial;
                            mq  <= {mq[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= div_shift;
                            mq  <= {mq[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                        mq  <= {booth_sum[0], mq[WIDTH-1:1]};
                        q_1 <= mq[0];
                    end
                end
                ST_FIX: begin
                    lo          <= lo_fix;
                    hi          <= hi_fix;
                    div_by_zero <= dbz_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed vector table, hand-written handshake/reset
// sequences, and random operations checked against an arithmetic model.
module tb_mul_div_unit;

    localparam int unsigned WIDTH = 32;
    localparam int LAT = WIDTH + 1;

    logic             clock;
    logic             clear;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             div_by_zero;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.WIDTH(WIDTH)) dut (
        .clock(clock), .clear(clear), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .lo(lo), .hi(hi), .div_by_zero(div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic, SV division truncates toward zero
    task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] elo, output logic [31:0] ehi, output logic edbz);
        longint sp, sq, sr;
        logic [63:0] up;
        edbz = 1'b0;
        case (o)
            2'd0: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                up = 64'(sp);
                elo = up[31:0]; ehi = up[63:32];
            end
            2'd1: begin
                up = {32'd0, x} * {32'd0, y};
                elo = up[31:0]; ehi = up[63:32];
            end
            default: begin
                if (y == 32'd0) begin
                    elo = 32'hFFFF_FFFF; ehi = x; edbz = 1'b1;
                end else if (o == 2'd2) begin
                    sq = longint'($signed(x)) / longint'($signed(y));
                    sr = longint'($signed(x)) % longint'($signed(y));
                    elo = 32'(sq); ehi = 32'(sr);
                end else begin
                    elo = x / y; ehi = x % y;
                end
            end
        endcase
    endtask

    // Issue one op from IDLE, wait for done with a bound, return results; ends in IDLE
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] rlo, output logic [31:0] rhi, output logic rdbz);
        int lat;
        @(negedge clock);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clock); #1;
        start = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        chk("busy_after_accept", 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(LAT));
        rlo = lo; rhi = hi; rdbz = div_by_zero;
        chk("busy_at_done", 32'(busy), 32'd0);
        @(posedge clock); #1;
        chk("done_pulse_width", 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] rlo, rhi, elo, ehi;
        logic        rdbz, edbz;
        int          n, pulses;
        logic [31:0] x, y;
        logic [1:0]  o;

        vecs[0]  = '{2'd0, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0};
        vecs[1]  = '{2'd1, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[2]  = '{2'd0, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0};
        vecs[3]  = '{2'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
        vecs[4]  = '{2'd3, 32'd100,       32'd7,          32'd14,        32'd2,         1'b0};
        vecs[5]  = '{2'd3, 32'd100,       32'd0,          32'hFFFF_FFFF, 32'd100,       1'b1};
        vecs[6]  = '{2'd0, 32'd2,         32'd3,          32'd6,         32'd0,         1'b0};
        vecs[7]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         1'b0};
        vecs[8]  = '{2'd0, 32'h8000_0000, 32'h8000_0000,  32'd0,         32'h4000_0000, 1'b0};
        vecs[9]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFE, 1'b0};
        vecs[10] = '{2'd2, 32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'd1,         1'b0};
        vecs[11] = '{2'd2, 32'h8000_0000, 32'd0,          32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[12] = '{2'd3, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 32'd0,         1'b0};
        vecs[13] = '{2'd3, 32'd5,         32'd9,          32'd0,         32'd5,         1'b0};
        vecs[14] = '{2'd1, 32'h8000_0000, 32'h8000_0000,  32'd0,         32'h4000_0000, 1'b0};
        vecs[15] = '{2'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF, 1'b0};

        clear = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clock);
        clear = 1'b1;

        // Directed table, issued back to back in the first IDLE cycle after each done
        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, rlo, rhi, rdbz);
            chk($sformatf("vec%0d_lo", i), rlo, vecs[i].lo);
            chk($sformatf("vec%0d_hi", i), rhi, vecs[i].hi);
            chk($sformatf("vec%0d_dbz", i), 32'(rdbz), 32'(vecs[i].dbz));
        end

        // Start pulses while busy and during DONE must be ignored
        @(negedge clock);
        start = 1'b1; op = 2'd0; a = 32'd5; b = 32'd6;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        start = 1'b1; op = 2'd3; a = 32'd9; b = 32'd9;
        @(posedge clock); #1;
        start = 1'b0;
        chk("busy_ignores_start", 32'(busy), 32'd1);
        n = 10;
        while (!done && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        chk("ignored_latency", 32'(n), 32'(LAT));
        chk("ignored_lo", lo, 32'd30);
        chk("ignored_hi", hi, 32'd0);
        start = 1'b1; op = 2'd3; a = 32'd1; b = 32'd1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("done_start_idle", 32'(busy), 32'd0);
        @(posedge clock); #1;
        chk("done_start_ignored", 32'(busy), 32'd0);

        // Asynchronous abort in the middle of a divide
        @(negedge clock);
        start = 1'b1; op = 2'd2; a = 32'hFFFF_FF00; b = 32'd3;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        clear = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_hi", hi, 32'd0);
        @(negedge clock);
        clear = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (done) pulses++;
        end
        chk("abort_no_done", 32'(pulses), 32'd0);

        // Random operations against the model, biased toward edge operands
        for (int i = 0; i < 200; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 9))
                0: y = 32'd0;
                1: y = 32'hFFFF_FFFF;
                2: x = 32'h8000_0000;
                3: y = 32'($urandom_range(1, 15));
                default: ;
            endcase
            model(o, x, y, elo, ehi, edbz);
            run_op(o, x, y, rlo, rhi, rdbz);
            chk($sformatf("rnd%0d_op%0d_lo", i, o), rlo, elo);
            chk($sformatf("rnd%0d_op%0d_hi", i, o), rhi, ehi);
            chk($sformatf("rnd%0d_op%0d_dbz", i, o), 32'(rdbz), 32'(edbz));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
